// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, reads the combinational instruction ROM and
// buffers (pc, instruction) pairs in a circular queue drained by decode via valid/ready.
module instr_fetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned MEM_SIZE    = 1024,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_instruction,
  output logic [63:0] deq_pc,
  output logic        fetch_halted
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [31:0]       mem_instr_q [QUEUE_DEPTH];
  logic [63:0]       mem_pc_q    [QUEUE_DEPTH];

  logic              deq;
  logic              enq;
  logic              pc_oob;
  logic              queue_full;
  logic [1:0]        unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Compared as pc >= MEM_SIZE - 3 so a PC near 2^64 cannot wrap the pc + 3 sum.
  assign pc_oob     = (pc_q >= (64'(MEM_SIZE) - 64'd3));
  assign queue_full = (count_q == CntW'(QUEUE_DEPTH));

  assign imem_address = pc_q;
  assign fetch_halted = (state_q == StHalt);
  assign deq_valid    = (count_q != '0);
  assign deq          = deq_valid & deq_ready;

  // A full queue still accepts a word when the head leaves in the same cycle.
  assign enq = (state_q == StFetch) && !redirect_valid && !pc_oob && (!queue_full || deq);

  // Empty queue presents zeros rather than stale storage.
  always_comb begin
    deq_instruction = '0;
    deq_pc          = '0;
    if (deq_valid) begin
      deq_instruction = mem_instr_q[head_q];
      deq_pc          = mem_pc_q[head_q];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (redirect_valid) begin
      // Flush wins over everything, including a same-cycle dequeue.
      state_d = StFetch;
      pc_d    = {redirect_pc[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
        pc_d   = pc_q + 64'd4;
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (state_q == StFetch && pc_oob) begin
        state_d = StHalt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      pc_q    <= {RESET_PC[63:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by deq_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr_q[tail_q] <= imem_instruction;
      mem_pc_q[tail_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: ROM model, scoreboard of expected (pc, instr) pairs
// popped on every dequeue handshake, plus point checks of outputs.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instruction;
  logic [63:0] deq_pc;
  logic        fetch_halted;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [95:0] sb [$];

  instr_fetch_queue #(
    .QUEUE_DEPTH (4),
    .MEM_SIZE    (1024),
    .RESET_PC    (64'h0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .deq_valid        (deq_valid),
    .deq_ready        (deq_ready),
    .deq_instruction  (deq_instruction),
    .deq_pc           (deq_pc),
    .fetch_halted     (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return 32'h5A00_0000 ^ {a[17:2], ~a[17:2]};
  endfunction

  assign imem_instruction = rom_word(imem_address);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    sb.push_back({pc, rom_word(pc)});
  endtask

  // Called at a negedge: score any handshake, then advance one full cycle.
  task automatic step();
    logic [95:0] e;
    if (deq_valid && deq_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_deq: observed pc %h expected no dequeue", deq_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("deq_pc", deq_pc, e[95:32]);
        chk("deq_instr", {32'h0, deq_instruction}, {32'h0, e[31:0]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    deq_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_deq_valid", {63'h0, deq_valid}, 64'h0);
    chk("rst_halted", {63'h0, fetch_halted}, 64'h0);
    chk("rst_addr", imem_address, 64'h0);
    chk("rst_deq_pc", deq_pc, 64'h0);
    chk("rst_deq_instr", {32'h0, deq_instruction}, 64'h0);

    // Streaming: one instruction per cycle, no gaps.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(64'(i * 4));
    chk("first_cycle_empty", {63'h0, deq_valid}, 64'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {63'h0, deq_valid}, 64'h1);
      step();
    end

    // Back-pressure: fill to depth, stall, then drain with full+deq.
    reset_n   = 1'b0;
    deq_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    steps(6);
    chk("stall_addr", imem_address, 64'h10);
    chk("stall_head_pc", deq_pc, 64'h0);
    chk("stall_head_instr", {32'h0, deq_instruction}, {32'h0, rom_word(64'h0)});
    for (int i = 0; i < 5; i++) push_exp(64'(i * 4));
    deq_ready = 1'b1;
    step();
    chk("full_deq_enq_addr", imem_address, 64'h14);
    deq_ready = 1'b0;
    step();
    chk("still_full_addr", imem_address, 64'h14);
    deq_ready = 1'b1;
    steps(4);

    // Redirect with three entries queued.
    reset_n   = 1'b0;
    deq_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    steps(3);
    chk("three_queued_valid", {63'h0, deq_valid}, 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", {63'h0, deq_valid}, 64'h0);
    chk("redir_addr", imem_address, 64'h100);
    push_exp(64'h100);
    push_exp(64'h104);
    push_exp(64'h108);
    deq_ready = 1'b1;
    step();
    chk("redir_head_pc", deq_pc, 64'h100);
    chk("redir_head_instr", {32'h0, deq_instruction}, {32'h0, rom_word(64'h100)});
    steps(3);

    // Redirect with a same-cycle dequeue, then run off the end of ROM.
    push_exp(64'h10C);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3F0;
    step();
    redirect_valid = 1'b0;
    deq_ready      = 1'b0;
    chk("end_flush_valid", {63'h0, deq_valid}, 64'h0);
    chk("end_not_halted", {63'h0, fetch_halted}, 64'h0);
    for (int i = 0; i < 4; i++) push_exp(64'h3F0 + 64'(i * 4));
    steps(4);
    chk("end_addr", imem_address, 64'h400);
    chk("end_fetch_state", {63'h0, fetch_halted}, 64'h0);
    step();
    chk("halted", {63'h0, fetch_halted}, 64'h1);
    chk("halted_queue_kept", {63'h0, deq_valid}, 64'h1);
    steps(2);
    chk("halted_addr_hold", imem_address, 64'h400);
    deq_ready = 1'b1;
    steps(4);
    chk("drained", {63'h0, deq_valid}, 64'h0);
    steps(2);
    chk("halt_no_enq", {63'h0, deq_valid}, 64'h0);
    chk("halt_sticky", {63'h0, fetch_halted}, 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    step();
    redirect_valid = 1'b0;
    chk("resume_halted", {63'h0, fetch_halted}, 64'h0);
    chk("resume_addr", imem_address, 64'h20);
    push_exp(64'h20);
    push_exp(64'h24);
    steps(3);

    // Redirect to out-of-range PC: FETCH for one cycle, then HALT.
    deq_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h500;
    step();
    redirect_valid = 1'b0;
    chk("oob_redir_fetch", {63'h0, fetch_halted}, 64'h0);
    chk("oob_redir_flush", {63'h0, deq_valid}, 64'h0);
    step();
    chk("oob_redir_halt", {63'h0, fetch_halted}, 64'h1);
    chk("oob_redir_addr", imem_address, 64'h500);

    // Asynchronous reset mid-cycle with two entries queued.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    step();
    redirect_valid = 1'b0;
    steps(2);
    chk("two_queued_pc", deq_pc, 64'h40);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, deq_valid}, 64'h0);
    chk("async_rst_pc", deq_pc, 64'h0);
    chk("async_rst_addr", imem_address, 64'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    deq_ready = 1'b1;
    push_exp(64'h0);
    push_exp(64'h4);
    steps(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
